uart_report_mux: RTL and testbench



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_cmd_parser.sv | 52 +++++
 rtl/uart_report_mux.sv | 168 ++++++++++++++++
 tb/tb_uart_report_mux.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART channel report mux: FSM encodings, ASCII bytes,
// frame geometry and the BCD/alarm helper functions.
package uart_pkg;

  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE  = 2'd0;
  localparam state_e ST_LATCH = 2'd1;
  localparam state_e ST_SEND  = 2'd2;
  localparam state_e ST_GAP   = 2'd3;

  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_SEMI  = 8'h3B;
  localparam logic [7:0] ASC_BANG  = 8'h21;
  localparam logic [7:0] ASC_QMARK = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  localparam int BYTES_PER_CH = 12;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASC_ZERO + {4'd0, d}) : ASC_QMARK;
  endfunction

  // Invalid BCD never raises an alarm.
  function automatic logic over_thres(input logic [7:0] bcd, input logic [6:0] th);
    logic [6:0] val;
    val = 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    if (bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) return 1'b0;
    return val >= th;
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Two-byte '+k' / '-k' command decoder; emits one-cycle per-channel
// increment/decrement strobes on the completing rx byte.
module uart_cmd_parser #(
  parameter int CH_NUM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [CH_NUM-1:0] inc_stb,
  output logic [CH_NUM-1:0] dec_stb
);
  import uart_pkg::*;

  logic       pend_q, pend_d;
  logic       dir_inc_q, dir_inc_d;
  logic [7:0] idx;

  always_comb begin
    pend_d    = pend_q;
    dir_inc_d = dir_inc_q;
    inc_stb   = '0;
    dec_stb   = '0;
    idx       = rx_data - ASC_ZERO;
    if (rx_valid) begin
      // An opcode byte always (re)starts a command, even mid-command.
      if (rx_data == ASC_PLUS || rx_data == ASC_MINUS) begin
        pend_d    = 1'b1;
        dir_inc_d = (rx_data == ASC_PLUS);
      end else if (pend_q) begin
        pend_d = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
          if (idx == 8'(k)) begin
            inc_stb[k] = dir_inc_q;
            dec_stb[k] = !dir_inc_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      dir_inc_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      dir_inc_q <= dir_inc_d;
    end
  end

endmodule

// File: rtl/uart_report_mux.sv
// Periodic ASCII report of per-channel BCD values and alarm thresholds over a
// valid/ready byte stream; thresholds are adjusted by rx commands.
//
// state    | meaning
// ST_IDLE  | one cycle after reset release
// ST_LATCH | snapshot ch_data and thresholds
// ST_SEND  | stream 12*CH_NUM+2 frame bytes
// ST_GAP   | wait CLK_FRE*1000*PERIOD_MS cycles
module uart_report_mux #(
  parameter int CLK_FRE    = 50,
  parameter int CH_NUM     = 4,
  parameter int PERIOD_MS  = 1000,
  parameter int THRES_INIT = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_NUM*8-1:0] ch_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [CH_NUM-1:0]   thres_en
);
  import uart_pkg::*;

  localparam int GAP_CYC = CLK_FRE * 1000 * PERIOD_MS;
  localparam int GAP_W   = $clog2(GAP_CYC) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  state_e              state_q, state_d;
  logic [3:0]          pos_q, pos_d;
  logic [3:0]          ch_q, ch_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CH_NUM*8-1:0] snap_data_q, snap_data_d;
  logic [6:0]          snap_thres_q [CH_NUM];
  logic [6:0]          snap_thres_d [CH_NUM];
  logic [6:0]          thres_q [CH_NUM];
  logic [6:0]          thres_d [CH_NUM];
  logic [CH_NUM-1:0]   thres_en_q, thres_en_d;
  logic [CH_NUM-1:0]   inc_stb, dec_stb;
  logic [7:0]          sel_data, cur_byte;
  logic [6:0]          sel_thres;

  uart_cmd_parser #(.CH_NUM(CH_NUM)) u_parser (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .inc_stb  (inc_stb),
    .dec_stb  (dec_stb)
  );

  always_comb begin
    thres_en_d = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      thres_d[k] = thres_q[k];
      if (inc_stb[k] && thres_q[k] < 7'd99)      thres_d[k] = thres_q[k] + 7'd1;
      else if (dec_stb[k] && thres_q[k] != 7'd0) thres_d[k] = thres_q[k] - 7'd1;
      thres_en_d[k] = over_thres(ch_data[k*8 +: 8], thres_q[k]);
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_thres = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_q == 4'(k)) begin
        sel_data  = snap_data_q[k*8 +: 8];
        sel_thres = snap_thres_q[k];
      end
    end
  end

  // ch_q == CH_NUM selects the CR/LF trailer.
  always_comb begin
    cur_byte = ASC_SPACE;
    if (ch_q < 4'(CH_NUM)) begin
      case (pos_q)
        4'd0:    cur_byte = ASC_C;
        4'd1:    cur_byte = ASC_ZERO + {4'd0, ch_q};
        4'd2:    cur_byte = ASC_EQ;
        4'd3:    cur_byte = bcd_to_ascii(sel_data[7:4]);
        4'd4:    cur_byte = bcd_to_ascii(sel_data[3:0]);
        4'd5:    cur_byte = ASC_SPACE;
        4'd6:    cur_byte = ASC_T;
        4'd7:    cur_byte = ASC_EQ;
        4'd8:    cur_byte = ASC_ZERO + 8'(sel_thres / 7'd10);
        4'd9:    cur_byte = ASC_ZERO + 8'(sel_thres % 7'd10);
        4'd10:   cur_byte = over_thres(sel_data, sel_thres) ? ASC_BANG : ASC_SPACE;
        default: cur_byte = ASC_SEMI;
      endcase
    end else begin
      cur_byte = (pos_q == 4'd0) ? ASC_CR : ASC_LF;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    ch_d         = ch_q;
    gap_d        = gap_q;
    snap_data_d  = snap_data_q;
    snap_thres_d = snap_thres_q;
    case (state_q)
      ST_IDLE: state_d = ST_LATCH;
      ST_LATCH: begin
        snap_data_d  = ch_data;
        snap_thres_d = thres_q;
        pos_d        = '0;
        ch_d         = '0;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (ch_q < 4'(CH_NUM)) begin
            if (pos_q == 4'(BYTES_PER_CH - 1)) begin
              pos_d = '0;
              ch_d  = ch_q + 4'd1;
            end else begin
              pos_d = pos_q + 4'd1;
            end
          end else if (pos_q == 4'd1) begin
            pos_d   = '0;
            ch_d    = '0;
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end
      end
      default: begin
        if (gap_q == '0) state_d = ST_LATCH;
        else             gap_d   = gap_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      ch_q        <= '0;
      gap_q       <= '0;
      snap_data_q <= '0;
      thres_en_q  <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        snap_thres_q[k] <= '0;
        thres_q[k]      <= 7'(THRES_INIT);
      end
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      ch_q         <= ch_d;
      gap_q        <= gap_d;
      snap_data_q  <= snap_data_d;
      snap_thres_q <= snap_thres_d;
      thres_q      <= thres_d;
      thres_en_q   <= thres_en_d;
    end
  end

  assign tx_valid = (state_q == ST_SEND);
  assign tx_data  = tx_valid ? cur_byte : 8'h00;
  assign thres_en = thres_en_q;

endmodule

// File: tb/tb_uart_report_mux.sv
// Directed/randomized bench for uart_report_mux with a string-level frame model
// and a byte-level threshold/command model.
module tb_uart_report_mux;

  localparam int CH  = 2;
  localparam int GAP = 1 * 1000 * 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   ch_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [1:0]    thres_en;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_thres [CH];
  bit  m_pend;
  bit  m_inc;
  byte rxq [$];

  uart_report_mux #(.CLK_FRE(1), .CH_NUM(CH), .PERIOD_MS(1), .THRES_INIT(40)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_data  (ch_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .thres_en (thres_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string vis(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  task automatic chk_str(input string tag, input string got, input string exp);
    n_tests++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(got), vis(exp));
    end
  endtask

  function automatic string dig(input int d);
    return (d <= 9) ? $sformatf("%0d", d) : "?";
  endfunction

  function automatic bit ch_alarm(input int k);
    int hi, lo;
    hi = int'(ch_data[k*8+4 +: 4]);
    lo = int'(ch_data[k*8 +: 4]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo >= m_thres[k]);
  endfunction

  function automatic string exp_frame();
    string s;
    s = "";
    for (int k = 0; k < CH; k++) begin
      s = {s, $sformatf("C%0d=%s%s T=%02d%s;", k, dig(int'(ch_data[k*8+4 +: 4])),
           dig(int'(ch_data[k*8 +: 4])), m_thres[k], ch_alarm(k) ? "!" : " ")};
    end
    return {s, "\r\n"};
  endfunction

  function automatic logic [1:0] exp_en();
    logic [1:0] e;
    for (int k = 0; k < CH; k++) e[k] = ch_alarm(k);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) m_thres[k] = 40;
    m_pend = 0;
    m_inc  = 0;
  endtask

  task automatic model_rx(input byte b);
    int k;
    if (b == "+" || b == "-") begin
      m_pend = 1;
      m_inc  = (b == "+");
    end else if (m_pend) begin
      m_pend = 0;
      k = int'(b) - int'("0");
      if (k >= 0 && k < CH) begin
        if (m_inc) m_thres[k] = (m_thres[k] < 99) ? m_thres[k] + 1 : 99;
        else       m_thres[k] = (m_thres[k] > 0)  ? m_thres[k] - 1 : 0;
      end
    end
  endtask

  // Called once per negedge: present the next queued rx byte (with random idles).
  task automatic drive_rx_cycle();
    if (rxq.size() > 0 && $urandom_range(0, 3) != 0) begin
      rx_data  = rxq.pop_front();
      rx_valid = 1'b1;
      model_rx(rx_data);
    end else begin
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_rx();
    int guard;
    guard = 0;
    while (rxq.size() > 0 && guard < 5000) begin
      @(negedge clk);
      drive_rx_cycle();
      guard++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Collect one frame. Model expectation is captured when the first byte appears.
  task automatic recv_frame(input bit rnd_ready, input int abort_at, input int chg_at,
                            input logic [15:0] chg_val, output string got,
                            output string exp, output int idle_cnt);
    int   nb, cyc;
    bit   started, done, prev_stall;
    logic [7:0] prev_d;
    nb = 0; cyc = 0; started = 0; done = 0; prev_stall = 0; prev_d = '0;
    got = ""; exp = ""; idle_cnt = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid_held", tx_valid, 1'b1);
        chk("stall_data_held", tx_data, prev_d);
      end
      if (tx_valid && !started) begin
        started = 1;
        exp = exp_frame();
      end
      if (!started) idle_cnt++;
      if (started && nb == chg_at) ch_data = chg_val;
      if (started && abort_at >= 0 && nb == abort_at) begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("reset_drops_valid", tx_valid, 1'b0);
        chk("reset_clears_data", tx_data, 8'h00);
        model_reset();
        done = 1;
      end else begin
        if (started) drive_rx_cycle();
        else         rx_valid = 1'b0;
        tx_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stall = tx_valid && !tx_ready;
        prev_d     = tx_data;
        if (tx_valid && tx_ready) begin
          got = {got, $sformatf("%c", tx_data)};
          nb++;
          if (tx_data == 8'h0A) done = 1;
        end
      end
    end
    if (!done) chk("frame_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    string got, exp;
    int    idl;
    byte   pool [6];

    pool = '{"+", "-", "0", "1", "2", "x"};
    rst_n    = 1'b1;
    ch_data  = 16'h4225;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    idle(3);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_thres_en", thres_en, 2'b00);
    rst_n = 1'b1;

    // Basic frame with ready held high.
    recv_frame(0, -1, -1, '0, got, exp, idl);
    chk_str("frame1_literal", got, "C0=25 T=40 ;C1=42 T=40!;\r\n");
    chk_str("frame1_model", got, exp);
    chk("thres_en_basic", thres_en, 2'b10);

    // Random backpressure; also measures the end-to-start gap.
    recv_frame(1, -1, -1, '0, got, exp, idl);
    chk_str("frame2_backpressure", got, exp);
    chk("gap_cycles", 64'(idl), 64'(GAP + 1));

    // Discarded / restarted commands: only thres[0] moves.
    push_str("+x1+5-+0");
    send_rx();
    idle(3);
    chk("thres_en_after_cmds", thres_en, exp_en());
    recv_frame(1, -1, -1, '0, got, exp, idl);
    chk_str("frame3_literal", got, "C0=25 T=41 ;C1=42 T=40!;\r\n");
    chk_str("frame3_model", got, exp);

    // Saturation at both ends.
    for (int i = 0; i < 60; i++) push_str("+1");
    for (int i = 0; i < 50; i++) push_str("-0");
    send_rx();
    idle(3);
    chk("thres_en_saturated", thres_en, 2'b01);
    recv_frame(0, -1, -1, '0, got, exp, idl);
    chk_str("frame4_literal", got, "C0=25 T=00!;C1=42 T=99 ;\r\n");
    chk_str("frame4_model", got, exp);

    // Random rx during SEND plus a mid-frame ch_data change.
    for (int i = 0; i < 16; i++) rxq.push_back(pool[$urandom_range(0, 5)]);
    recv_frame(1, -1, 5, 16'h0A99, got, exp, idl);
    chk_str("frame5_snapshot_held", got, exp);
    send_rx();
    idle(3);
    chk("thres_en_live", thres_en, exp_en());
    recv_frame(1, -1, -1, '0, got, exp, idl);
    chk_str("frame6_new_snapshot", got, exp);
    chk_str("frame6_ch1_invalid", got.substr(12, 23), $sformatf("C1=0? T=%02d ;", m_thres[1]));

    // Reset in the middle of byte 7.
    recv_frame(0, 7, -1, '0, got, exp, idl);
    chk_str("partial_before_reset", got, "C0=99 T");
    idle(3);
    chk("reset_mid_thres_en", thres_en, 2'b00);
    rst_n = 1'b1;
    recv_frame(0, -1, -1, '0, got, exp, idl);
    chk_str("frame_after_reset", got, "C0=99 T=40!;C1=0? T=40 ;\r\n");
    idle(3);
    chk("thres_en_after_reset", thres_en, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
